// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the burst-length and wrap helpers used by the manager.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Undefined-length INCR uses len; a zero length still issues one beat.
    function automatic logic [4:0] burst_beats(hburst_t burst, logic [4:0] len);
        case (burst)
            BURST_SINGLE:             return 5'd1;
            BURST_INCR:               return (len == 5'd0) ? 5'd1 : len;
            BURST_WRAP4, BURST_INCR4: return 5'd4;
            BURST_WRAP8, BURST_INCR8: return 5'd8;
            default:                  return 5'd16;
        endcase
    endfunction

    function automatic logic is_wrap(hburst_t burst);
        return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address: linear increment or wrap inside the burst window,
// plus a flag marking a step across a 1KB boundary.
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [2:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  cross_1kb
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [4:0]            beats;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        beats     = burst_beats(hburst_t'(burst), 5'd0);
        wrap_mask = (ADDR_WIDTH'(beats) << size) - ADDR_WIDTH'(1);
        incr_addr = addr + step;
        // Wrapping keeps every bit above the window and only cycles the low bits.
        next_addr = is_wrap(hburst_t'(burst)) ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                              : incr_addr;
        cross_1kb = next_addr[ADDR_WIDTH-1:10] != addr[ADDR_WIDTH-1:10];
    end

endmodule

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: one command becomes one burst with address/data phases overlapped.
// Define AHB_MGR_1KB_SPLIT_EN to reissue INCR-type beats that cross a 1KB boundary as NONSEQ.
//
// state   | meaning
// S_IDLE  | bus idle, command port open
// S_ADDR  | address phase on the bus, previous beat may be in data phase
// S_DRAIN | last beat in data phase, bus already IDLE
// S_ERR   | ERROR seen, waiting for its second cycle
module ahb_lite_manager
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [3:0]            cmd_prot,
    input  logic [4:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            HTRANS,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_ERR} state_t;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    state_t                state, n_state;
    logic [4:0]            beats_left, n_beats_left;
    logic                  dp_valid, n_dp_valid;
    logic                  dp_write, n_dp_write;
    logic [1:0]            n_htrans;
    logic [ADDR_WIDTH-1:0] n_haddr;
    logic                  n_hwrite;
    logic [2:0]            n_hsize;
    logic [2:0]            n_hburst;
    logic [3:0]            n_hprot;
    logic [DATA_WIDTH-1:0] n_hwdata;
    logic [DATA_WIDTH-1:0] n_rd_data;
    logic                  n_rd_valid, n_done, n_err;
    logic                  go_idle;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cross_1kb;
    logic [1:0]            seq_type;

    ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .addr      (HADDR),
        .size      (HSIZE),
        .burst     (HBURST),
        .next_addr (next_addr),
        .cross_1kb (cross_1kb)
    );

`ifdef AHB_MGR_1KB_SPLIT_EN
    assign seq_type = (!is_wrap(hburst_t'(HBURST)) && cross_1kb) ? HTRANS_NONSEQ : HTRANS_SEQ;
`else
    logic unused_cross;
    assign seq_type     = HTRANS_SEQ;
    assign unused_cross = cross_1kb;
`endif

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            beats_left <= '0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            HTRANS     <= HTRANS_IDLE;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= '0;
            HBURST     <= '0;
            HPROT      <= '0;
            HWDATA     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= n_state;
            beats_left <= n_beats_left;
            dp_valid   <= n_dp_valid;
            dp_write   <= n_dp_write;
            HTRANS     <= n_htrans;
            HADDR      <= n_haddr;
            HWRITE     <= n_hwrite;
            HSIZE      <= n_hsize;
            HBURST     <= n_hburst;
            HPROT      <= n_hprot;
            HWDATA     <= n_hwdata;
            rd_data    <= n_rd_data;
            rd_valid   <= n_rd_valid;
            done       <= n_done;
            err        <= n_err;
        end
    end

    always_comb begin
        n_state      = state;
        n_beats_left = beats_left;
        n_dp_valid   = dp_valid;
        n_dp_write   = dp_write;
        n_htrans     = HTRANS;
        n_haddr      = HADDR;
        n_hwrite     = HWRITE;
        n_hsize      = HSIZE;
        n_hburst     = HBURST;
        n_hprot      = HPROT;
        n_hwdata     = HWDATA;
        n_rd_data    = rd_data;
        n_rd_valid   = 1'b0;
        n_done       = 1'b0;
        n_err        = 1'b0;
        cmd_ready    = 1'b0;
        wr_pop       = 1'b0;
        go_idle      = 1'b0;

        if (dp_valid && HREADY && !HRESP && !dp_write) begin
            n_rd_data  = HRDATA;
            n_rd_valid = 1'b1;
        end
        if (dp_valid && HREADY) begin
            n_dp_valid = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    n_htrans     = HTRANS_NONSEQ;
                    n_haddr      = cmd_addr;
                    n_hwrite     = cmd_write;
                    n_hsize      = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
                    n_hburst     = cmd_burst;
                    n_hprot      = cmd_prot;
                    n_beats_left = burst_beats(hburst_t'(cmd_burst), cmd_len);
                    n_state      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (dp_valid && HRESP) begin
                    // ERROR on the previous beat cancels the address phase now on the bus.
                    go_idle    = 1'b1;
                    n_dp_valid = 1'b0;
                    if (HREADY) begin
                        n_done  = 1'b1;
                        n_err   = 1'b1;
                        n_state = S_IDLE;
                    end else begin
                        n_state = S_ERR;
                    end
                end else if (HREADY) begin
                    wr_pop     = HWRITE;
                    n_dp_valid = 1'b1;
                    n_dp_write = HWRITE;
                    if (HWRITE) begin
                        n_hwdata = wr_data;
                    end
                    if (beats_left > 5'd1) begin
                        n_htrans     = seq_type;
                        n_haddr      = next_addr;
                        n_beats_left = beats_left - 5'd1;
                    end else begin
                        go_idle = 1'b1;
                        n_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (HRESP) begin
                    n_dp_valid = 1'b0;
                    if (HREADY) begin
                        n_done  = 1'b1;
                        n_err   = 1'b1;
                        n_state = S_IDLE;
                    end else begin
                        n_state = S_ERR;
                    end
                end else if (HREADY) begin
                    n_done  = 1'b1;
                    n_state = S_IDLE;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    n_done  = 1'b1;
                    n_err   = 1'b1;
                    n_state = S_IDLE;
                end
            end
            default: n_state = S_IDLE;
        endcase

        if (go_idle) begin
            n_htrans = HTRANS_IDLE;
            n_hwrite = 1'b0;
            n_hsize  = '0;
            n_hburst = '0;
            n_hprot  = '0;
        end
    end

endmodule

// File: doc/ahb_lite_manager.md
Name: ahb_lite_manager

Overview:
- AHB-Lite manager (initiator) engine that turns one command per burst into a legal address/data-phase sequence on the AHB-Lite bus.
- Sits between the testbench-side or system-side command source and any AHB-Lite subordinate.
- Pipelines the address phase of beat k+1 over the data phase of beat k.
- Honours HREADY wait states and HRESP errors.
- Its bus output is checked by the subordinate-side SVA bind: NONSEQ then SEQ, IDLE after every burst, zeroed controls while IDLE.

Parameters:
ADDR_WIDTH, 32, HADDR/cmd_addr width
DATA_WIDTH, 32, HWDATA/HRDATA width (HSIZE limited to log2(DATA_WIDTH/8))

Ports:
clk  in  1  bus clock
HRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write burst
cmd_addr  in  ADDR_WIDTH  start address (aligned to cmd_size)
cmd_burst  in  3  HBURST encoding
cmd_size  in  3  HSIZE encoding
cmd_prot  in  4  HPROT value
cmd_len  in  5  beats for INCR (1..16); ignored otherwise
wr_data  in  DATA_WIDTH  next write beat
wr_pop  out  1  wr_data consumed this cycle
rd_data  out  DATA_WIDTH  read beat
rd_valid  out  1  rd_data valid (one-cycle pulse)
done  out  1  burst finished (pulse)
err  out  1  burst terminated by ERROR (pulse, with done)
HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3 (BUSY never driven)
HADDR  out  ADDR_WIDTH  address
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  burst type
HPROT  out  4  protection
HWDATA  out  DATA_WIDTH  write data
HRDATA  in  DATA_WIDTH  read data
HREADY  in  1  transfer done / wait
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Single clock clk; reset HRESETn is asynchronous, active-low.
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - HTRANS=IDLE, HADDR=0.
  - State S_IDLE.
- All bus outputs are registered.
- Beats per burst:
  - SINGLE=1, INCR=cmd_len (0 treated as 1).
  - WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
- Next address:
  - INCR types: addr + (1<<HSIZE).
  - WRAP types: low bits wrap within a (beats<<HSIZE)-byte window; upper bits held.
- State S_IDLE:
  - cmd_ready=1; HTRANS=IDLE with HWRITE/HSIZE/HBURST all 0 (HADDR holds its last value).
  - On accept, latch the command, load beats_left, and go to S_ADDR.
  - Next cycle drives HTRANS=NONSEQ with cmd_addr.
- State S_ADDR (address phase in progress; a previous beat may be in its data phase):
  - Outputs are held while HREADY=0.
  - On HREADY=1: the current beat moves to its data phase.
    - If the current beat is a write, HWDATA<=wr_data and wr_pop=1 that same cycle.
    - If beats_left>1: HTRANS<=SEQ, HADDR<=next address, beats_left--.
    - If beats_left==1: HTRANS<=IDLE, HWRITE/HSIZE/HBURST<=0, go to S_DRAIN.
- Read capture: when a read beat's data phase completes (HREADY=1, HRESP=0), rd_data<=HRDATA and rd_valid=1 the following cycle.
- State S_DRAIN:
  - On HREADY=1 with HRESP=0: done=1 next cycle, go to S_IDLE.
  - So at least two IDLE cycles separate bursts.
- Error handling:
  - First ERROR cycle (HREADY=0, HRESP=1) in any data phase: next HTRANS<=IDLE, which cancels the pending address phase; remaining beats are discarded; go to S_ERR.
  - S_ERR: on HREADY=1, done=1 and err=1, then S_IDLE; no rd_valid/wr_pop for cancelled beats.
- HREADY=1 with HRESP=1 (protocol violation by subordinate): treated as ERROR completion, same as S_ERR exit.
- cmd_valid while busy: ignored (cmd_ready=0); no command queueing.
- Async reset mid-burst: outputs return to reset values immediately; no done pulse.

Optional Feature:
AHB_MGR_1KB_SPLIT_EN
- Defined: for INCR-type bursts, a beat whose address crosses a 1KB boundary is issued as NONSEQ instead of SEQ. HBURST is unchanged; the beat count is unaffected.
- Undefined: SEQ is always used after the first beat; the caller must guarantee no 1KB crossing.

Decomposition:
- Package ahb_pkg:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ), hburst_t enum (8 codes), hresp_t enum.
  - HSIZE constants.
  - Function burst_beats(hburst_t, len).
  - Function is_wrap(hburst_t).
- Sub-module ahb_addr_gen: combinational next-address (incr/wrap, 1KB-cross flag), parameterised by ADDR_WIDTH.

Test Plan:
- SINGLE write 0x100, size=2, HREADY=1 always -> HTRANS NONSEQ for one cycle, then IDLE; HWDATA=wr_data in data phase; wr_pop once; done 2 cycles after NONSEQ.
- INCR4 read 0x20, size=2, subordinate inserts 2 wait states on beat 2 -> HADDR 0x20,0x24,0x28,0x2C (NONSEQ,SEQ,SEQ,SEQ); HADDR held during waits; 4 rd_valid pulses in order; IDLE after.
- WRAP8 read 0x34, size=2 -> addresses 0x34,0x38,0x3C,0x20,0x24,0x28,0x2C,0x30; done once.
- INCR16 write with ERROR on beat 5 -> HTRANS IDLE the cycle after the first ERROR cycle; 5 wr_pops total; err=done=1; no further SEQ.
- INCR cmd_len=4 at 0x3F8, size=2, macro defined -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ; undefined -> 0x400 driven SEQ.
- HRESETn low during beat 3 of INCR8 -> HTRANS=IDLE, HADDR=0, cmd_ready=1 asynchronously; a new command after reset is issued as NONSEQ.
